// File: rtl/seg7_scan_driver_pkg.sv
// Shared constants and helpers for the scanned 7-segment driver.
// Segment polarity and counter sizing live here so the top and decoder agree.
package seg7_scan_driver_pkg;

    localparam logic [6:0] SEG_OFF_ACTIVE_LOW  = 7'h7F;
    localparam logic [6:0] SEG_OFF_ACTIVE_HIGH = 7'h00;

    function automatic logic [6:0] seg_off(input bit active_low);
        return active_low ? SEG_OFF_ACTIVE_LOW : SEG_OFF_ACTIVE_HIGH;
    endfunction

    // Width needed to hold 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hex_7seg_decoder.sv
// Hex nibble to 7-segment pattern, segments a..g on bits 0..6.
// Polarity follows COMMON_ANODE_CATHODE (1 = active-low).
module hex_7seg_decoder #(
    parameter int COMMON_ANODE_CATHODE = 1
) (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    logic [6:0] pattern;

    always_comb begin
        pattern = 7'h00;
        unique case (nibble)
            4'h0: pattern = 7'h3F;
            4'h1: pattern = 7'h06;
            4'h2: pattern = 7'h5B;
            4'h3: pattern = 7'h4F;
            4'h4: pattern = 7'h66;
            4'h5: pattern = 7'h6D;
            4'h6: pattern = 7'h7D;
            4'h7: pattern = 7'h07;
            4'h8: pattern = 7'h7F;
            4'h9: pattern = 7'h6F;
            4'hA: pattern = 7'h77;
            4'hB: pattern = 7'h7C;
            4'hC: pattern = 7'h39;
            4'hD: pattern = 7'h5E;
            4'hE: pattern = 7'h79;
            4'hF: pattern = 7'h71;
            default: pattern = 7'h00;
        endcase
    end

    assign seg = (COMMON_ANODE_CATHODE != 0) ? ~pattern : pattern;

endmodule

// File: rtl/seg7_scan_driver.sv
// Scanned multi-digit 7-segment driver with frame-synchronous value commit
// and optional leading-zero blanking.
module seg7_scan_driver
    import seg7_scan_driver_pkg::*;
#(
    parameter int DIGITS               = 4,
    parameter int REFRESH_DIV          = 50000,
    parameter int COMMON_ANODE_CATHODE = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [4*DIGITS-1:0]   i_value,
    input  logic                  i_load,
    input  logic                  i_blank_lz,
    output logic [6:0]            o_HEX,
    output logic [DIGITS-1:0]     o_dig,
    output logic                  o_frame
);

    localparam int                IDX_W      = cnt_width(DIGITS);
    localparam int                CNT_W      = cnt_width(REFRESH_DIV);
    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(DIGITS - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
    localparam bit                ACTIVE_LOW = (COMMON_ANODE_CATHODE != 0);
    localparam logic [6:0]        SEG_OFF    = seg_off(ACTIVE_LOW);
    localparam logic [DIGITS-1:0] DIG_OFF    = ACTIVE_LOW ? '1 : '0;

    logic [CNT_W-1:0]    cnt;
    logic [IDX_W-1:0]    idx;
    logic [4*DIGITS-1:0] shadow;
    logic [4*DIGITS-1:0] disp;
    logic                pending;
    logic                tick;
    logic                boundary;

    logic [DIGITS-1:0]   dig_onehot;
    logic [DIGITS-1:0]   lz_mask;
    logic [3:0]          nibble;
    logic [6:0]          seg;
    logic                blank_now;

    assign tick     = (cnt == CNT_LAST);
    assign boundary = tick && (idx == IDX_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (tick) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // A load landing on the boundary bypasses the shadow so the newest value wins.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            shadow  <= '0;
            disp    <= '0;
            pending <= 1'b0;
        end else begin
            if (i_load) begin
                shadow <= i_value;
            end
            if (boundary) begin
                pending <= 1'b0;
                if (i_load) begin
                    disp <= i_value;
                end else if (pending) begin
                    disp <= shadow;
                end
            end else if (i_load) begin
                pending <= 1'b1;
            end
        end
    end

    always_comb begin
        dig_onehot = '0;
        nibble     = 4'h0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                dig_onehot[k] = 1'b1;
                nibble        = disp[4*k +: 4];
            end
        end
    end

    // Digit k is a leading zero when it and every more significant nibble is zero.
    always_comb begin
        lz_mask = '0;
        for (int k = 1; k < DIGITS; k++) begin
            lz_mask[k] = ((disp >> (4*k)) == '0);
        end
    end

    assign blank_now = i_blank_lz && ((lz_mask & dig_onehot) != '0);

    hex_7seg_decoder #(
        .COMMON_ANODE_CATHODE(COMMON_ANODE_CATHODE)
    ) u_decoder (
        .nibble (nibble),
        .seg    (seg)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_dig   <= DIG_OFF;
            o_HEX   <= SEG_OFF;
            o_frame <= 1'b0;
        end else begin
            o_dig   <= ACTIVE_LOW ? ~dig_onehot : dig_onehot;
            o_HEX   <= blank_now ? SEG_OFF : seg;
            o_frame <= boundary;
        end
    end

endmodule
